// File: rtl/l2_arb_pkg.sv
// Shared types and defaults for the L1-to-L2 request arbiter.
package l2_arb_pkg;

  localparam int DEF_TAG_W   = 18;
  localparam int DEF_INDEX_W = 8;
  localparam int DEF_LINE_W  = 512;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Requester identities; also the bit positions in the request vector
  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/l2_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick between the I (bit 0) and D (bit 1) requesters.
module rr_arb2
  import l2_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // Contested requests go to whoever was not served last; otherwise the lone requester wins
  always_comb begin
    gnt_valid = |req;
    gnt_id    = OWN_I;
    if (req == 2'b11) begin
      gnt_id = ~last;
    end else if (req[1]) begin
      gnt_id = OWN_D;
    end
  end

endmodule

// File: rtl/l2_arbiter.sv
// Shares the single L2 request port between the instruction L1 and the data L1.
// The granted request is latched so the L2 sees a stable copy until it answers,
// and the L2 line is returned only to the requester that owned the transaction.
module l2_arbiter
  import l2_arb_pkg::*;
#(
  parameter int TAG_W   = DEF_TAG_W,
  parameter int INDEX_W = DEF_INDEX_W,
  parameter int LINE_W  = DEF_LINE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               read_I_ARB,
  input  logic [TAG_W-1:0]   tag_I_ARB,
  input  logic [INDEX_W-1:0] index_I_ARB,
  output logic               ready_ARB_I,
  output logic [LINE_W-1:0]  read_data_ARB_I,
  input  logic               read_D_ARB,
  input  logic               write_D_ARB,
  input  logic [TAG_W-1:0]   tag_D_ARB,
  input  logic [INDEX_W-1:0] index_D_ARB,
  input  logic [LINE_W-1:0]  write_data_D_ARB,
  output logic               ready_ARB_D,
  output logic [LINE_W-1:0]  read_data_ARB_D,
  output logic               read_L1_L2,
  output logic               write_L1_L2,
  output logic [TAG_W-1:0]   tag_L1_L2,
  output logic [INDEX_W-1:0] index_L1_L2,
  output logic [LINE_W-1:0]  write_data,
  input  logic               ready_L2_L1,
  input  logic [LINE_W-1:0]  read_data_L2_L1
);

  state_t             state_q, state_n;
  logic               owner_q, owner_n;
  logic               last_q, last_n;
  op_t                op_q, op_n;
  logic [TAG_W-1:0]   tag_q, tag_n;
  logic [INDEX_W-1:0] index_q, index_n;
  logic [LINE_W-1:0]  wdata_q, wdata_n;
  logic [LINE_W-1:0]  rdata_i_q, rdata_i_n;
  logic [LINE_W-1:0]  rdata_d_q, rdata_d_n;

  logic [1:0] req;
  logic       gnt_valid;
  logic       gnt_id;

  assign req = {read_D_ARB | write_D_ARB, read_I_ARB};

  rr_arb2 u_rr_arb2 (
    .req       (req),
    .last      (last_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // State and latch registers; reset abandons any transaction and starts with D as last served
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      last_q    <= OWN_D;
      op_q      <= OP_RD;
      tag_q     <= '0;
      index_q   <= '0;
      wdata_q   <= '0;
      rdata_i_q <= '0;
      rdata_d_q <= '0;
    end else begin
      state_q   <= state_n;
      owner_q   <= owner_n;
      last_q    <= last_n;
      op_q      <= op_n;
      tag_q     <= tag_n;
      index_q   <= index_n;
      wdata_q   <= wdata_n;
      rdata_i_q <= rdata_i_n;
      rdata_d_q <= rdata_d_n;
    end
  end

  // Grant in IDLE, wait for the L2 in BUSY, hand the line back in RESP
  always_comb begin
    state_n   = state_q;
    owner_n   = owner_q;
    last_n    = last_q;
    op_n      = op_q;
    tag_n     = tag_q;
    index_n   = index_q;
    wdata_n   = wdata_q;
    rdata_i_n = rdata_i_q;
    rdata_d_n = rdata_d_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          owner_n = gnt_id;
          state_n = BUSY;
          if (gnt_id == OWN_D) begin
            op_n    = write_D_ARB ? OP_WR : OP_RD;
            tag_n   = tag_D_ARB;
            index_n = index_D_ARB;
            wdata_n = write_data_D_ARB;
          end else begin
            op_n    = OP_RD;
            tag_n   = tag_I_ARB;
            index_n = index_I_ARB;
            wdata_n = '0;
          end
        end
      end
      BUSY: begin
        if (ready_L2_L1) begin
          if (owner_q == OWN_D) begin
            rdata_d_n = read_data_L2_L1;
          end else begin
            rdata_i_n = read_data_L2_L1;
          end
          last_n  = owner_q;
          state_n = RESP;
        end
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign read_L1_L2      = (state_q == BUSY) && (op_q == OP_RD);
  assign write_L1_L2     = (state_q == BUSY) && (op_q == OP_WR);
  assign tag_L1_L2       = tag_q;
  assign index_L1_L2     = index_q;
  assign write_data      = wdata_q;
  assign ready_ARB_I     = (state_q == RESP) && (owner_q == OWN_I);
  assign ready_ARB_D     = (state_q == RESP) && (owner_q == OWN_D);
  assign read_data_ARB_I = rdata_i_q;
  assign read_data_ARB_D = rdata_d_q;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter and its round-robin picker.
module tb_l2_arbiter;

  logic         clk;
  logic         rst;
  logic         read_I_ARB;
  logic [17:0]  tag_I_ARB;
  logic [7:0]   index_I_ARB;
  logic         ready_ARB_I;
  logic [511:0] read_data_ARB_I;
  logic         read_D_ARB;
  logic         write_D_ARB;
  logic [17:0]  tag_D_ARB;
  logic [7:0]   index_D_ARB;
  logic [511:0] write_data_D_ARB;
  logic         ready_ARB_D;
  logic [511:0] read_data_ARB_D;
  logic         read_L1_L2;
  logic         write_L1_L2;
  logic [17:0]  tag_L1_L2;
  logic [7:0]   index_L1_L2;
  logic [511:0] write_data;
  logic         ready_L2_L1;
  logic [511:0] read_data_L2_L1;

  logic [1:0] rr_req;
  logic       rr_last;
  logic       rr_valid;
  logic       rr_id;

  int passes;
  int total;

  logic [511:0] exp_i_data;
  logic [511:0] exp_d_data;
  logic [511:0] line;
  logic [511:0] wb_line;
  logic         owner_d;

  l2_arbiter #(.TAG_W(18), .INDEX_W(8), .LINE_W(512)) dut (
    .clk              (clk),
    .rst              (rst),
    .read_I_ARB       (read_I_ARB),
    .tag_I_ARB        (tag_I_ARB),
    .index_I_ARB      (index_I_ARB),
    .ready_ARB_I      (ready_ARB_I),
    .read_data_ARB_I  (read_data_ARB_I),
    .read_D_ARB       (read_D_ARB),
    .write_D_ARB      (write_D_ARB),
    .tag_D_ARB        (tag_D_ARB),
    .index_D_ARB      (index_D_ARB),
    .write_data_D_ARB (write_data_D_ARB),
    .ready_ARB_D      (ready_ARB_D),
    .read_data_ARB_D  (read_data_ARB_D),
    .read_L1_L2       (read_L1_L2),
    .write_L1_L2      (write_L1_L2),
    .tag_L1_L2        (tag_L1_L2),
    .index_L1_L2      (index_L1_L2),
    .write_data       (write_data),
    .ready_L2_L1      (ready_L2_L1),
    .read_data_L2_L1  (read_data_L2_L1)
  );

  rr_arb2 u_rr (
    .req       (rr_req),
    .last      (rr_last),
    .gnt_valid (rr_valid),
    .gnt_id    (rr_id)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ri, input logic [17:0] ti, input logic [7:0] ii,
                               input logic rd, input logic wd, input logic [17:0] td,
                               input logic [7:0] id, input logic rdy);
    read_I_ARB  = ri;
    tag_I_ARB   = ti;
    index_I_ARB = ii;
    read_D_ARB  = rd;
    write_D_ARB = wd;
    tag_D_ARB   = td;
    index_D_ARB = id;
    ready_L2_L1 = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
  endtask

  // Directed sequence covering picker, reset, single request, contention, write decode, mid-BUSY changes and reset abort
  initial begin
    logic [1:0] tab_req  [5];
    logic       tab_last [5];
    logic       tab_v    [5];
    logic       tab_id   [5];

    passes = 0;
    total  = 0;
    exp_i_data = '0;
    exp_d_data = '0;
    rst = 1'b1;
    write_data_D_ARB = '0;
    read_data_L2_L1  = '0;
    applyStimulus(1'b0, 18'h0, 8'h0, 1'b0, 1'b0, 18'h0, 8'h0, 1'b0);

    $display("[TB] round-robin picker");
    tab_req  = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
    tab_last = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1};
    tab_v    = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b1};
    tab_id   = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
    for (int k = 0; k < 5; k++) begin
      rr_req  = tab_req[k];
      rr_last = tab_last[k];
      #1;
      checkOutput("rr_valid", 512'(rr_valid), 512'(tab_v[k]));
      if (tab_v[k]) checkOutput("rr_id", 512'(rr_id), 512'(tab_id[k]));
    end

    $display("[TB] reset values");
    repeat (3) nextCycle();
    checkOutput("rst_read",   512'(read_L1_L2),  512'd0);
    checkOutput("rst_write",  512'(write_L1_L2), 512'd0);
    checkOutput("rst_rdy_i",  512'(ready_ARB_I), 512'd0);
    checkOutput("rst_rdy_d",  512'(ready_ARB_D), 512'd0);
    checkOutput("rst_tag",    512'(tag_L1_L2),   512'd0);
    checkOutput("rst_index",  512'(index_L1_L2), 512'd0);
    checkOutput("rst_wdata",  write_data,        512'd0);
    rst = 1'b0;

    $display("[TB] single I read, L2 answers after 4 cycles");
    applyStimulus(1'b1, 18'h00A5, 8'h12, 1'b0, 1'b0, 18'h0, 8'h0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      nextCycle();
      checkOutput("t1_read",  512'(read_L1_L2),  512'd1);
      checkOutput("t1_write", 512'(write_L1_L2), 512'd0);
      checkOutput("t1_tag",   512'(tag_L1_L2),   512'h00A5);
      checkOutput("t1_index", 512'(index_L1_L2), 512'h12);
      checkOutput("t1_rdy_i", 512'(ready_ARB_I), 512'd0);
    end
    line = {16{32'hCAFE_0001}};
    read_data_L2_L1 = line;
    ready_L2_L1 = 1'b1;
    nextCycle();
    exp_i_data = line;
    checkOutput("t1_resp_rdy_i", 512'(ready_ARB_I), 512'd1);
    checkOutput("t1_resp_rdy_d", 512'(ready_ARB_D), 512'd0);
    checkOutput("t1_resp_data",  read_data_ARB_I,   exp_i_data);
    checkOutput("t1_resp_read",  512'(read_L1_L2),  512'd0);
    applyStimulus(1'b0, 18'h00A5, 8'h12, 1'b0, 1'b0, 18'h0, 8'h0, 1'b0);
    nextCycle();
    checkOutput("t1_idle_rdy_i", 512'(ready_ARB_I), 512'd0);
    checkOutput("t1_idle_read",  512'(read_L1_L2),  512'd0);
    checkOutput("t1_idle_data",  read_data_ARB_I,   exp_i_data);

    $display("[TB] continuous contention after reset");
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    exp_i_data = '0;
    exp_d_data = '0;
    applyStimulus(1'b1, 18'h111, 8'h01, 1'b1, 1'b0, 18'h222, 8'h02, 1'b1);
    for (int n = 0; n < 4; n++) begin
      owner_d = (n % 2) == 1;
      nextCycle();
      checkOutput("t2_busy_read", 512'(read_L1_L2), 512'd1);
      checkOutput("t2_busy_tag",  512'(tag_L1_L2),  owner_d ? 512'h222 : 512'h111);
      line = {16{32'h2000_0000 + 32'(n)}};
      read_data_L2_L1 = line;
      nextCycle();
      if (owner_d) exp_d_data = line;
      else exp_i_data = line;
      checkOutput("t2_resp_rdy_i",  512'(ready_ARB_I), 512'(!owner_d));
      checkOutput("t2_resp_rdy_d",  512'(ready_ARB_D), 512'(owner_d));
      checkOutput("t2_resp_read",   512'(read_L1_L2),  512'd0);
      checkOutput("t2_resp_data_i", read_data_ARB_I,   exp_i_data);
      checkOutput("t2_resp_data_d", read_data_ARB_D,   exp_d_data);
      if (n == 3) applyStimulus(1'b0, 18'h0, 8'h0, 1'b0, 1'b0, 18'h0, 8'h0, 1'b0);
      nextCycle();
      checkOutput("t2_idle_read",  512'(read_L1_L2),  512'd0);
      checkOutput("t2_idle_rdy_i", 512'(ready_ARB_I), 512'd0);
      checkOutput("t2_idle_rdy_d", 512'(ready_ARB_D), 512'd0);
    end

    $display("[TB] D read and write together decodes as write");
    wb_line = {16'hDEAD, {30{16'h5A5A}}, 16'hBEEF};
    write_data_D_ARB = wb_line;
    applyStimulus(1'b0, 18'h0, 8'h0, 1'b1, 1'b1, 18'h3C3C, 8'h77, 1'b0);
    nextCycle();
    checkOutput("t3_write", 512'(write_L1_L2), 512'd1);
    checkOutput("t3_read",  512'(read_L1_L2),  512'd0);
    checkOutput("t3_wdata", write_data,        wb_line);
    checkOutput("t3_tag",   512'(tag_L1_L2),   512'h3C3C);
    line = {16{32'h3333_3333}};
    read_data_L2_L1 = line;
    ready_L2_L1 = 1'b1;
    nextCycle();
    exp_d_data = line;
    checkOutput("t3_rdy_d",  512'(ready_ARB_D), 512'd1);
    checkOutput("t3_rdy_i",  512'(ready_ARB_I), 512'd0);
    checkOutput("t3_resp_w", 512'(write_L1_L2), 512'd0);
    applyStimulus(1'b0, 18'h0, 8'h0, 1'b0, 1'b0, 18'h0, 8'h0, 1'b0);
    write_data_D_ARB = '0;
    nextCycle();

    $display("[TB] I request and tag change while D is in flight");
    applyStimulus(1'b0, 18'h0, 8'h0, 1'b1, 1'b0, 18'h0D0D, 8'h44, 1'b0);
    nextCycle();
    checkOutput("t4_busy_tag0", 512'(tag_L1_L2), 512'h0D0D);
    applyStimulus(1'b1, 18'h1111, 8'h55, 1'b1, 1'b0, 18'h0D0D, 8'h44, 1'b0);
    nextCycle();
    checkOutput("t4_busy_tag1", 512'(tag_L1_L2), 512'h0D0D);
    tag_I_ARB = 18'h2222;
    nextCycle();
    checkOutput("t4_busy_tag2", 512'(tag_L1_L2),   512'h0D0D);
    checkOutput("t4_busy_idx",  512'(index_L1_L2), 512'h44);
    line = {16{32'h4444_0D0D}};
    read_data_L2_L1 = line;
    ready_L2_L1 = 1'b1;
    nextCycle();
    exp_d_data = line;
    checkOutput("t4_rdy_d",   512'(ready_ARB_D), 512'd1);
    checkOutput("t4_rdy_i",   512'(ready_ARB_I), 512'd0);
    checkOutput("t4_data_d",  read_data_ARB_D,   exp_d_data);
    checkOutput("t4_hold_i",  read_data_ARB_I,   exp_i_data);
    applyStimulus(1'b1, 18'h2222, 8'h55, 1'b0, 1'b0, 18'h0, 8'h0, 1'b0);
    nextCycle();
    checkOutput("t4_idle_read", 512'(read_L1_L2), 512'd0);
    nextCycle();
    checkOutput("t4_i_read", 512'(read_L1_L2), 512'd1);
    checkOutput("t4_i_tag",  512'(tag_L1_L2),  512'h2222);
    line = {16{32'h4444_2222}};
    read_data_L2_L1 = line;
    ready_L2_L1 = 1'b1;
    nextCycle();
    exp_i_data = line;
    checkOutput("t4_i_rdy",  512'(ready_ARB_I), 512'd1);
    checkOutput("t4_i_data", read_data_ARB_I,   exp_i_data);
    applyStimulus(1'b0, 18'h0, 8'h0, 1'b0, 1'b0, 18'h0, 8'h0, 1'b0);
    nextCycle();

    $display("[TB] reset during BUSY");
    applyStimulus(1'b1, 18'h0ABC, 8'h34, 1'b0, 1'b0, 18'h0, 8'h0, 1'b0);
    nextCycle();
    checkOutput("t5_busy_read", 512'(read_L1_L2), 512'd1);
    #2;
    rst = 1'b1;
    #1;
    exp_i_data = '0;
    exp_d_data = '0;
    checkOutput("t5_async_read",  512'(read_L1_L2),  512'd0);
    checkOutput("t5_async_write", 512'(write_L1_L2), 512'd0);
    checkOutput("t5_async_tag",   512'(tag_L1_L2),   512'd0);
    checkOutput("t5_async_idx",   512'(index_L1_L2), 512'd0);
    checkOutput("t5_async_rdy_i", 512'(ready_ARB_I), 512'd0);
    checkOutput("t5_async_data",  read_data_ARB_I,   exp_i_data);
    ready_L2_L1 = 1'b1;
    nextCycle();
    checkOutput("t5_held_rdy_i", 512'(ready_ARB_I), 512'd0);
    checkOutput("t5_held_rdy_d", 512'(ready_ARB_D), 512'd0);
    applyStimulus(1'b1, 18'h0005, 8'h05, 1'b1, 1'b0, 18'h0006, 8'h06, 1'b0);
    rst = 1'b0;
    nextCycle();
    checkOutput("t5_grant_read", 512'(read_L1_L2), 512'd1);
    checkOutput("t5_grant_tag",  512'(tag_L1_L2),  512'h0005);
    line = {16{32'h5555_0005}};
    read_data_L2_L1 = line;
    ready_L2_L1 = 1'b1;
    nextCycle();
    exp_i_data = line;
    checkOutput("t5_rdy_i", 512'(ready_ARB_I), 512'd1);
    checkOutput("t5_rdy_d", 512'(ready_ARB_D), 512'd0);
    applyStimulus(1'b0, 18'h0, 8'h0, 1'b0, 1'b0, 18'h0, 8'h0, 1'b0);
    nextCycle();

    $display("[TB] L2 ready while IDLE");
    read_data_L2_L1 = {16{32'hBAD0_BAD0}};
    ready_L2_L1 = 1'b1;
    nextCycle();
    checkOutput("t6_rdy_i",  512'(ready_ARB_I), 512'd0);
    checkOutput("t6_rdy_d",  512'(ready_ARB_D), 512'd0);
    checkOutput("t6_read",   512'(read_L1_L2),  512'd0);
    checkOutput("t6_write",  512'(write_L1_L2), 512'd0);
    checkOutput("t6_data_i", read_data_ARB_I,   exp_i_data);
    applyStimulus(1'b1, 18'h0077, 8'h07, 1'b0, 1'b0, 18'h0, 8'h0, 1'b0);
    nextCycle();
    checkOutput("t6_grant_read", 512'(read_L1_L2), 512'd1);
    checkOutput("t6_grant_tag",  512'(tag_L1_L2),  512'h0077);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/l2_arbiter.md
# l2_arbiter

Two-requester arbiter that shares the single L1-to-L2 request port of the L2 cache between the instruction L1 (read-only) and the data L1 (read and write-back). It sits between both L1 controllers and the L2 top-level block. It grants one requester at a time with round-robin fairness, holds the granted request stable toward the L2 until the L2 signals ready, and returns the registered response only to the owner.

## Interface
Parameters:
- TAG_W, 18, tag width in bits
- INDEX_W, 8, set index width in bits
- LINE_W, 512, cache line width in bits

Ports:
- clk  in  1  clock; everything is rising-edge
- rst  in  1  reset, asynchronous, active-high
- read_I_ARB  in  1  instruction L1 line read request; level, held until ready_ARB_I
- tag_I_ARB / index_I_ARB  in  TAG_W / INDEX_W  instruction request address
- ready_ARB_I  out  1  one-cycle completion pulse to the instruction L1
- read_data_ARB_I  out  LINE_W  returned line; valid while ready_ARB_I is high
- read_D_ARB / write_D_ARB  in  1 / 1  data L1 read and write-back requests; level, held until ready_ARB_D
- tag_D_ARB / index_D_ARB  in  TAG_W / INDEX_W  data request address
- write_data_D_ARB  in  LINE_W  write-back line
- ready_ARB_D  out  1  one-cycle completion pulse to the data L1
- read_data_ARB_D  out  LINE_W  returned line; valid while ready_ARB_D is high
- read_L1_L2 / write_L1_L2  out  1 / 1  request to the L2
- tag_L1_L2 / index_L1_L2  out  TAG_W / INDEX_W  address to the L2
- write_data  out  LINE_W  write-back line to the L2
- ready_L2_L1  in  1  L2 completion
- read_data_L2_L1  in  LINE_W  L2 returned line; valid while ready_L2_L1 is high

## Operation
- The FSM has three states: IDLE, BUSY, RESP. Registers:
  - owner (0 = I, 1 = D)
  - last (the last owner served)
  - the latched op, tag, index and write data
  - rdata
- A requester is active when I has read_I_ARB high, or D has read_D_ARB or write_D_ARB high.
- IDLE:
  - With exactly one requester active, grant it.
  - With both active, grant the one that is not last.
  - On grant: latch that requester's op, tag, index and write data; set owner; go to BUSY.
  - With no requester active, stay in IDLE.
- D op decode: write_D_ARB has precedence over read_D_ARB. If both are high, latch a write.
- BUSY:
  - Drive read_L1_L2 or write_L1_L2 from the latched op, plus the latched tag, index and write data, every cycle.
  - On ready_L2_L1: capture read_data_L2_L1 into rdata, set last = owner, go to RESP.
- RESP:
  - Pulse ready_ARB_x for the owner only.
  - read_data_ARB_x = rdata for the owner. The non-owner's data output holds its previous value.
  - Deassert the L2 request. Go to IDLE.
- Requester input changes during BUSY or RESP are ignored, because the latched copy drives the L2.
- ready_L2_L1 is ignored in IDLE and RESP.
- A requester that drops its request before its ready arrives does not abort the transaction. The transaction completes, and the ready pulse is still issued.

## Timing
- Reset values:
  - state = IDLE, last = D, owner = I
  - all request and ready outputs 0; tag, index and data outputs 0
- Reset is allowed in any state. It abandons any in-flight transaction with no ready pulse to either side; the L2 sees its request drop.
- Grant latency: a request seen in IDLE at cycle n puts the L2 request high at cycle n+1.
- Response latency: ready_L2_L1 at cycle k produces ready_ARB_x at cycle k+1. The state is IDLE at cycle k+2.
- Minimum transaction length is 3 cycles (IDLE, BUSY, RESP) when the L2 answers in the first BUSY cycle.
- Requesters deassert in the cycle after they see ready. IDLE at k+2 therefore sees the served requester inactive, so there is no double grant.
- Fairness: under continuous contention, grants alternate I, D, I, D. The first contested grant after reset goes to I.
- The L2 request outputs are registered. No combinational path exists from requester inputs to L2 outputs, or from ready_L2_L1 to ready_ARB_x.

## Structure
- Package l2_arb_pkg holds:
  - the TAG_W, INDEX_W and LINE_W defaults
  - the state enum {IDLE, BUSY, RESP}
  - owner encodings OWN_I = 0, OWN_D = 1
  - op encodings OP_RD and OP_WR
- Sub-module rr_arb2: a combinational two-way round-robin pick. Inputs are req[1:0] and last; outputs are gnt_valid and gnt_id. Verify it standalone.
- The top module holds the FSM, the latch registers and the response register.

## Test plan
- I read alone, tag 0x00A5, index 0x12; L2 ready 4 cycles after the request -> read_L1_L2 high for exactly those cycles with tag 0x00A5 and index 0x12; ready_ARB_I is a 1-cycle pulse carrying the L2 line; ready_ARB_D stays 0.
- I and D reads both asserted continuously, L2 ready on the first BUSY cycle -> grant order I, D, I, D; one L2 request every 3 cycles.
- D asserts read_D_ARB and write_D_ARB together with write data 0xDEAD…BEEF -> write_L1_L2 = 1, read_L1_L2 = 0, write_data = 0xDEAD…BEEF.
- D granted; I raises a request and changes its tag mid-BUSY -> the L2 tag stays at D's latched value; I is granted only after D's RESP cycle.
- rst asserted during BUSY -> all outputs 0 asynchronously; no ready pulse; after release, a contested request is granted to I.
- ready_L2_L1 pulsed while IDLE -> no state change and no ready output.
